alu_issue_ctrl: RTL and testbench

Registered, multi-cycle successor to the combinational ALU control decoder. It accepts one decoded instruction per handshake and decodes func/alu_op into an ALU control code and an integer/FP unit select. It holds that control stable for an op-dependent latency (integer mult/div, FP ops) and signals completion. It sits between the ID/EX pipeline register and the ALU/FPU pair, and drives the pipeline stall.

---
 rtl/alu_ctrl_pkg.sv | 93 +++++++++
 rtl/alu_decode.sv | 81 ++++++++
 rtl/alu_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - encodings, state type and latency classes for the ALU issue controller
package alu_ctrl_pkg;

    localparam int CTRL_W = 4;
    localparam int FUNC_W = 6;
    localparam int AOP_W  = 4;

    typedef logic [CTRL_W-1:0] ctrl_t;
    typedef logic [FUNC_W-1:0] func_t;
    typedef logic [AOP_W-1:0]  aop_t;

    // Integer ALU control codes
    localparam ctrl_t ALU_ADD  = 4'd0;
    localparam ctrl_t ALU_SUB  = 4'd1;
    localparam ctrl_t ALU_ADDU = 4'd2;
    localparam ctrl_t ALU_SUBU = 4'd3;
    localparam ctrl_t ALU_AND  = 4'd4;
    localparam ctrl_t ALU_XOR  = 4'd5;
    localparam ctrl_t ALU_NOR  = 4'd6;
    localparam ctrl_t ALU_SLL  = 4'd7;
    localparam ctrl_t ALU_SRL  = 4'd8;
    localparam ctrl_t ALU_SLT  = 4'd9;
    localparam ctrl_t ALU_MUL  = 4'd10;
    localparam ctrl_t ALU_DIV  = 4'd11;
    localparam ctrl_t ALU_SRA  = 4'd12;
    localparam ctrl_t ALU_OR   = 4'd13;
    localparam ctrl_t ALU_LUI  = 4'd14;

    // FPU control codes (only meaningful with alu_select = 1)
    localparam ctrl_t FPU_ADDF = 4'd0;
    localparam ctrl_t FPU_SUBF = 4'd1;
    localparam ctrl_t FPU_MULF = 4'd2;
    localparam ctrl_t FPU_NEGF = 4'd3;
    localparam ctrl_t FPU_DIVF = 4'd4;
    localparam ctrl_t FPU_INVF = 4'd5;
    localparam ctrl_t FPU_SF   = 4'd6;
    localparam ctrl_t FPU_LF   = 4'd7;

    localparam func_t F_ADD  = 6'b100000;
    localparam func_t F_SUB  = 6'b100010;
    localparam func_t F_ADDU = 6'b100001;
    localparam func_t F_SUBU = 6'b100011;
    localparam func_t F_AND  = 6'b100100;
    localparam func_t F_XOR  = 6'b100110;
    localparam func_t F_NOR  = 6'b100111;
    localparam func_t F_SLL  = 6'b000000;
    localparam func_t F_SLLV = 6'b000100;
    localparam func_t F_SRL  = 6'b000010;
    localparam func_t F_SLT  = 6'b101010;
    localparam func_t F_MUL  = 6'b011000;
    localparam func_t F_DIV  = 6'b011010;
    localparam func_t F_SRAV = 6'b000110;
    localparam func_t F_SRA  = 6'b000011;
    localparam func_t F_OR   = 6'b100101;
    localparam func_t F_ADDF = 6'b111111;
    localparam func_t F_SUBF = 6'b111110;
    localparam func_t F_MULF = 6'b111101;
    localparam func_t F_NEGF = 6'b111011;
    localparam func_t F_DIVF = 6'b110111;
    localparam func_t F_INVF = 6'b101111;
    localparam func_t F_SF   = 6'b011111;
    localparam func_t F_LF   = 6'b001111;

    localparam aop_t AOP_RTYPE = 4'd0;
    localparam aop_t AOP_ADD   = 4'd1;
    localparam aop_t AOP_ADDU  = 4'd2;
    localparam aop_t AOP_AND   = 4'd3;
    localparam aop_t AOP_XOR   = 4'd4;
    localparam aop_t AOP_OR    = 4'd5;
    localparam aop_t AOP_SLT   = 4'd6;
    localparam aop_t AOP_LUI   = 4'd7;
    localparam aop_t AOP_SUBU  = 4'd8;

    typedef enum logic {IDLE, EXEC} state_e;

    typedef enum logic [2:0] {LAT_ONE, LAT_MUL, LAT_DIV, LAT_FMUL, LAT_FDIV, LAT_FPU} lat_class_e;

    function automatic lat_class_e lat_class_f(input logic fp, input ctrl_t ctrl);
        if (fp) begin
            if (ctrl == FPU_MULF)                       return LAT_FMUL;
            if (ctrl == FPU_DIVF || ctrl == FPU_INVF)   return LAT_FDIV;
            return LAT_FPU;
        end
        if (ctrl == ALU_MUL) return LAT_MUL;
        if (ctrl == ALU_DIV) return LAT_DIV;
        return LAT_ONE;
    endfunction

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational func/alu_op decode to control code, unit select and latency
module alu_decode
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_LENGTH   = 6,
    parameter int ALU_OP_LENGTH  = 4,
    parameter int CONTROL_LENGTH = 4,
    parameter int MUL_LAT        = 4,
    parameter int DIV_LAT        = 8,
    parameter int FMUL_LAT       = 3,
    parameter int FDIV_LAT       = 10,
    parameter int FPU_LAT        = 2,
    parameter int LAT_W          = 4
) (
    input  logic [FUNCT_LENGTH-1:0]   func,
    input  logic [ALU_OP_LENGTH-1:0]  alu_op,
    output logic [CONTROL_LENGTH-1:0] control,
    output logic                      alu_select,
    output logic [LAT_W-1:0]          latency
);

    ctrl_t      ctrl;
    lat_class_e lat_class;

    always_comb begin
        ctrl       = ALU_ADD;
        alu_select = 1'b0;
        if (alu_op == AOP_RTYPE) begin
            case (func)
                F_ADD:         ctrl = ALU_ADD;
                F_SUB:         ctrl = ALU_SUB;
                F_ADDU:        ctrl = ALU_ADDU;
                F_SUBU:        ctrl = ALU_SUBU;
                F_AND:         ctrl = ALU_AND;
                F_XOR:         ctrl = ALU_XOR;
                F_NOR:         ctrl = ALU_NOR;
                F_SLL, F_SLLV: ctrl = ALU_SLL;
                F_SRL:         ctrl = ALU_SRL;
                F_SLT:         ctrl = ALU_SLT;
                F_MUL:         ctrl = ALU_MUL;
                F_DIV:         ctrl = ALU_DIV;
                F_SRAV, F_SRA: ctrl = ALU_SRA;
                F_OR:          ctrl = ALU_OR;
                F_ADDF: begin ctrl = FPU_ADDF; alu_select = 1'b1; end
                F_SUBF: begin ctrl = FPU_SUBF; alu_select = 1'b1; end
                F_MULF: begin ctrl = FPU_MULF; alu_select = 1'b1; end
                F_NEGF: begin ctrl = FPU_NEGF; alu_select = 1'b1; end
                F_DIVF: begin ctrl = FPU_DIVF; alu_select = 1'b1; end
                F_INVF: begin ctrl = FPU_INVF; alu_select = 1'b1; end
                F_SF:   begin ctrl = FPU_SF;   alu_select = 1'b1; end
                F_LF:   begin ctrl = FPU_LF;   alu_select = 1'b1; end
                default:       ctrl = ALU_ADD;
            endcase
        end else begin
            case (alu_op)
                AOP_ADD:  ctrl = ALU_ADD;
                AOP_ADDU: ctrl = ALU_ADDU;
                AOP_AND:  ctrl = ALU_AND;
                AOP_XOR:  ctrl = ALU_XOR;
                AOP_OR:   ctrl = ALU_OR;
                AOP_SLT:  ctrl = ALU_SLT;
                AOP_LUI:  ctrl = ALU_LUI;
                AOP_SUBU: ctrl = ALU_SUBU;
                default:  ctrl = ALU_ADD;
            endcase
        end

        lat_class = lat_class_f(alu_select, ctrl);
        case (lat_class)
            LAT_MUL:  latency = LAT_W'(MUL_LAT);
            LAT_DIV:  latency = LAT_W'(DIV_LAT);
            LAT_FMUL: latency = LAT_W'(FMUL_LAT);
            LAT_FDIV: latency = LAT_W'(FDIV_LAT);
            LAT_FPU:  latency = LAT_W'(FPU_LAT);
            default:  latency = LAT_W'(1);
        endcase
    end

    assign control = CONTROL_LENGTH'(ctrl);

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - registered ALU/FPU issue control with op-dependent latency and stall
module alu_issue_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int FUNCT_LENGTH   = 6,
    parameter int ALU_OP_LENGTH  = 4,
    parameter int CONTROL_LENGTH = 4,
    parameter int MUL_LAT        = 4,
    parameter int DIV_LAT        = 8,
    parameter int FMUL_LAT       = 3,
    parameter int FDIV_LAT       = 10,
    parameter int FPU_LAT        = 2
) (
    input  logic                      clk,
    input  logic                      rst_b,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FUNCT_LENGTH-1:0]   func,
    input  logic [ALU_OP_LENGTH-1:0]  alu_op,
    input  logic                      flush,
    output logic [CONTROL_LENGTH-1:0] control,
    output logic                      alu_select,
    output logic                      busy,
    output logic                      done
);

    localparam int MAX_LAT = max_i(max_i(max_i(MUL_LAT, DIV_LAT), max_i(FMUL_LAT, FDIV_LAT)), FPU_LAT);
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [CONTROL_LENGTH-1:0] control_q, control_d;
    logic                      alu_select_q, alu_select_d;
    logic                      done_q, done_d;

    logic [CONTROL_LENGTH-1:0] dec_control;
    logic                      dec_select;
    logic [CNT_W-1:0]          dec_latency;
    logic                      accept;

    alu_decode #(
        .FUNCT_LENGTH  (FUNCT_LENGTH),
        .ALU_OP_LENGTH (ALU_OP_LENGTH),
        .CONTROL_LENGTH(CONTROL_LENGTH),
        .MUL_LAT       (MUL_LAT),
        .DIV_LAT       (DIV_LAT),
        .FMUL_LAT      (FMUL_LAT),
        .FDIV_LAT      (FDIV_LAT),
        .FPU_LAT       (FPU_LAT),
        .LAT_W         (CNT_W)
    ) u_decode (
        .func      (func),
        .alu_op    (alu_op),
        .control   (dec_control),
        .alu_select(dec_select),
        .latency   (dec_latency)
    );

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        control_d    = control_q;
        alu_select_d = alu_select_q;
        done_d       = 1'b0;

        // Flush outranks both a new accept and a completion due at this edge
        if (flush) begin
            state_d      = IDLE;
            cnt_d        = '0;
            control_d    = '0;
            alu_select_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        control_d    = dec_control;
                        alu_select_d = dec_select;
                        cnt_d        = dec_latency - CNT_W'(1);
                        if (dec_latency == CNT_W'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            control_q    <= '0;
            alu_select_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            control_q    <= control_d;
            alu_select_q <= alu_select_d;
            done_q       <= done_d;
        end
    end

    assign control    = control_q;
    assign alu_select = alu_select_q;
    assign busy       = (state_q == EXEC);
    assign done       = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - self-checking bench for alu_issue_ctrl against a cycle-time reference model
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst_b;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] func;
    logic [3:0] alu_op;
    logic       flush;
    logic [3:0] control;
    logic       alu_select;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .alu_op    (alu_op),
        .flush     (flush),
        .control   (control),
        .alu_select(alu_select),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference decode: key func -> sel*16 + ctrl, used only when alu_op == 0
    int rtype_tab[int];
    int aop_tab[16] = '{0, 0, 2, 4, 5, 13, 9, 14, 3, 0, 0, 0, 0, 0, 0, 0};
    logic [5:0] pool[24] = '{6'o40, 6'o42, 6'o41, 6'o43, 6'o44, 6'o46, 6'o47, 6'o00, 6'o04, 6'o02,
                             6'o52, 6'o30, 6'o32, 6'o06, 6'o03, 6'o45, 6'o77, 6'o76, 6'o75, 6'o73,
                             6'o67, 6'o57, 6'o37, 6'o17};

    initial begin
        rtype_tab[6'b100000] = 0;  rtype_tab[6'b100010] = 1;  rtype_tab[6'b100001] = 2;
        rtype_tab[6'b100011] = 3;  rtype_tab[6'b100100] = 4;  rtype_tab[6'b100110] = 5;
        rtype_tab[6'b100111] = 6;  rtype_tab[6'b000000] = 7;  rtype_tab[6'b000100] = 7;
        rtype_tab[6'b000010] = 8;  rtype_tab[6'b101010] = 9;  rtype_tab[6'b011000] = 10;
        rtype_tab[6'b011010] = 11; rtype_tab[6'b000110] = 12; rtype_tab[6'b000011] = 12;
        rtype_tab[6'b100101] = 13;
        rtype_tab[6'b111111] = 16; rtype_tab[6'b111110] = 17; rtype_tab[6'b111101] = 18;
        rtype_tab[6'b111011] = 19; rtype_tab[6'b110111] = 20; rtype_tab[6'b101111] = 21;
        rtype_tab[6'b011111] = 22; rtype_tab[6'b001111] = 23;
    end

    function automatic int ref_code(input logic [5:0] f, input logic [3:0] op);
        if (op != 4'd0) return aop_tab[op];
        if (rtype_tab.exists(int'(f))) return rtype_tab[int'(f)];
        return 0;
    endfunction

    function automatic int ref_lat(input int code);
        case (code)
            10:      return 4;
            11:      return 8;
            18:      return 3;
            20, 21:  return 10;
            default: return (code >= 16) ? 2 : 1;
        endcase
    endfunction

    // Model state: absolute cycle numbers for the end of busy and the done pulse
    int m_cyc        = 0;
    int m_busy_until = -100;
    int m_done_at    = -100;
    int m_code       = 0;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_cyc        <= 0;
            m_busy_until <= -100;
            m_done_at    <= -100;
            m_code       <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (flush) begin
                m_busy_until <= -100;
                m_done_at    <= -100;
                m_code       <= 0;
            end else if (in_valid && !(m_cyc <= m_busy_until)) begin
                m_code       <= ref_code(func, alu_op);
                m_busy_until <= m_cyc + ref_lat(ref_code(func, alu_op)) - 1;
                m_done_at    <= m_cyc + ref_lat(ref_code(func, alu_op));
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_control", int'(control), m_code % 16);
        chk("model_select", int'(alu_select), m_code / 16);
        chk("model_busy", int'(busy), (m_cyc <= m_busy_until) ? 1 : 0);
        chk("model_ready", int'(in_ready), (m_cyc <= m_busy_until) ? 0 : 1);
        chk("model_done", int'(done), (m_cyc == m_done_at) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [3:0] op);
        in_valid = v;
        func     = f;
        alu_op   = op;
    endtask

    initial begin
        int nb;
        int guard;
        int ndone;
        rst_b = 1'b0;
        flush = 1'b0;
        drive(1'b0, 6'd0, 4'd0);
        tick(); tick();
        chk("rst_control", int'(control), 0);
        chk("rst_select", int'(alu_select), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(in_ready), 1);
        rst_b = 1'b1;
        tick();

        drive(1'b1, 6'b100000, 4'd0);
        tick();
        drive(1'b0, 6'd0, 4'd0);
        chk("add_done", int'(done), 1);
        chk("add_control", int'(control), 0);
        chk("add_busy", int'(busy), 0);

        drive(1'b1, 6'b100010, 4'd0);
        tick();
        chk("b2b_sub", int'(control), 1);
        chk("b2b_done0", int'(done), 1);
        chk("b2b_ready0", int'(in_ready), 1);
        drive(1'b1, 6'b000000, 4'd7);
        tick();
        chk("b2b_lui", int'(control), 14);
        chk("b2b_done1", int'(done), 1);
        drive(1'b1, 6'b000000, 4'd5);
        tick();
        chk("b2b_or", int'(control), 13);
        chk("b2b_done2", int'(done), 1);
        chk("b2b_ready2", int'(in_ready), 1);

        drive(1'b1, 6'b011010, 4'd0);
        tick();
        drive(1'b1, 6'b100000, 4'd0);
        nb = 0;
        guard = 1;
        while (!done && guard < 30) begin
            if (busy) begin
                nb++;
                chk("div_hold", int'(control), 11);
            end
            tick();
            guard++;
        end
        chk("div_busy_cycles", nb, 7);
        chk("div_done_latency", guard, 8);
        chk("div_done_control", int'(control), 11);
        tick();
        drive(1'b0, 6'd0, 4'd0);
        chk("div_queued_control", int'(control), 0);
        chk("div_queued_done", int'(done), 1);

        drive(1'b1, 6'b110111, 4'd0);
        tick();
        drive(1'b0, 6'd0, 4'd0);
        chk("divf_select", int'(alu_select), 1);
        chk("divf_control", int'(control), 4);
        chk("divf_busy", int'(busy), 1);
        tick(); tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", int'(busy), 0);
        chk("flush_control", int'(control), 0);
        chk("flush_select", int'(alu_select), 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) ndone++;
            tick();
        end
        chk("flush_no_done", ndone, 0);

        drive(1'b1, 6'b111101, 4'd0);
        tick();
        drive(1'b0, 6'd0, 4'd0);
        chk("mulf_busy", int'(busy), 1);
        chk("mulf_control", int'(control), 2);
        #1 rst_b = 1'b0;
        #1;
        chk("midrst_control", int'(control), 0);
        chk("midrst_select", int'(alu_select), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(in_ready), 1);
        rst_b = 1'b1;
        drive(1'b1, 6'b111111, 4'd0);
        tick();
        drive(1'b0, 6'd0, 4'd0);
        chk("addf_select", int'(alu_select), 1);
        chk("addf_busy", int'(busy), 1);
        chk("addf_early_done", int'(done), 0);
        tick();
        chk("addf_done", int'(done), 1);
        chk("addf_control", int'(control), 0);

        drive(1'b1, 6'b010101, 4'd0);
        tick();
        chk("unk_select", int'(alu_select), 0);
        chk("unk_done", int'(done), 1);
        drive(1'b1, 6'b000000, 4'd7);
        tick();
        drive(1'b1, 6'b100010, 4'd15);
        tick();
        drive(1'b0, 6'd0, 4'd0);
        chk("aop15_control", int'(control), 0);
        chk("aop15_done", int'(done), 1);

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            func     = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 23)] : 6'($urandom_range(0, 63));
            alu_op   = ($urandom_range(0, 9) < 6) ? 4'd0 : 4'($urandom_range(0, 15));
            flush    = ($urandom_range(0, 39) == 0);
            rst_b    = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_b = 1'b1;
        flush = 1'b0;
        drive(1'b0, 6'd0, 4'd0);
        for (int i = 0; i < 12; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
